// File: rtl/mult_issue_queue.sv
// mult_issue_queue: collapsing multiply issue queue (entry 0 oldest), CDB snoop, grant-to-issue latency 1 cycle.
// Dispatch silently dropped while queue_full (upstream stalls); MULT_IQ_BYPASS_EN makes CDB wakeups issuable same cycle.

package mult_iq_pkg;
  localparam int CDB_TAG_W  = 6;
  localparam int CDB_DATA_W = 32;

  typedef struct packed {
    logic                  cdb_valid;
    logic [CDB_TAG_W-1:0]  cdb_tag;
    logic [CDB_DATA_W-1:0] cdb_data;
    logic                  cdb_branch;
    logic                  cdb_branch_taken;
  } cdb_bus;

  typedef struct packed {
    logic                  issueblk_done;
    logic [CDB_DATA_W-1:0] issueque_rs_data;
    logic [CDB_DATA_W-1:0] issueque_rt_data;
    logic [CDB_TAG_W-1:0]  issueque_rd_tag;
  } int_data_exec_unit;
endpackage

module mult_issue_queue
  import mult_iq_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = CDB_TAG_W,
  parameter int DATA_W = CDB_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       dispatch_en,
  input  logic [DATA_W-1:0]          dispatch_rs_data,
  input  logic [TAG_W-1:0]           dispatch_rs_tag,
  input  logic                       dispatch_rs_valid,
  input  logic [DATA_W-1:0]          dispatch_rt_data,
  input  logic [TAG_W-1:0]           dispatch_rt_tag,
  input  logic                       dispatch_rt_valid,
  input  logic [TAG_W-1:0]           dispatch_rd_tag,
  input  cdb_bus                     cdb_mult_snoop,
  input  logic                       flush,
  input  logic                       issue_grant,
  output logic                       mult_req,
  output logic                       queue_full,
  output logic [$clog2(DEPTH+1)-1:0] queue_count,
  output int_data_exec_unit          mult_data_exec_unit
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic              vld;
    logic              rs_rdy;
    logic [TAG_W-1:0]  rs_tag;
    logic [DATA_W-1:0] rs_data;
    logic              rt_rdy;
    logic [TAG_W-1:0]  rt_tag;
    logic [DATA_W-1:0] rt_data;
    logic [TAG_W-1:0]  rd_tag;
  } entry_t;

  entry_t            r_q [DEPTH];
  logic [CW-1:0]     r_count;
  logic              r_full;
  int_data_exec_unit r_issue;

  entry_t            w_woken [DEPTH];
  entry_t            w_next  [DEPTH];
  entry_t            w_new;
  logic [DEPTH-1:0]  w_rs_wake;
  logic [DEPTH-1:0]  w_rt_wake;
  logic [DEPTH-1:0]  w_rdy;
  logic [IW-1:0]     w_sel;
  logic              w_issue;
  logic              w_disp_acc;
  logic              w_disp_rs_hit;
  logic              w_disp_rt_hit;
  logic [CW-1:0]     w_wr_idx;
  logic [CW-1:0]     w_count_nxt;
  int_data_exec_unit w_word;

  logic              w_cdb_vld;
  logic [TAG_W-1:0]  w_cdb_tag;
  logic [DATA_W-1:0] w_cdb_data;
  logic              w_unused_cdb;

  assign w_cdb_vld    = cdb_mult_snoop.cdb_valid;
  assign w_cdb_tag    = cdb_mult_snoop.cdb_tag;
  assign w_cdb_data   = cdb_mult_snoop.cdb_data;
  assign w_unused_cdb = cdb_mult_snoop.cdb_branch ^ cdb_mult_snoop.cdb_branch_taken;

  // Stored entries with this cycle's CDB broadcast already captured.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_woken[i]   = r_q[i];
      w_rs_wake[i] = w_cdb_vld && r_q[i].vld && !r_q[i].rs_rdy && (r_q[i].rs_tag == w_cdb_tag);
      w_rt_wake[i] = w_cdb_vld && r_q[i].vld && !r_q[i].rt_rdy && (r_q[i].rt_tag == w_cdb_tag);
      if (w_rs_wake[i]) begin
        w_woken[i].rs_rdy  = 1'b1;
        w_woken[i].rs_data = w_cdb_data;
      end
      if (w_rt_wake[i]) begin
        w_woken[i].rt_rdy  = 1'b1;
        w_woken[i].rt_data = w_cdb_data;
      end
    end
  end

  always_comb begin
    w_rdy = '0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef MULT_IQ_BYPASS_EN
      w_rdy[i] = w_woken[i].vld && w_woken[i].rs_rdy && w_woken[i].rt_rdy;
`else
      w_rdy[i] = r_q[i].vld && r_q[i].rs_rdy && r_q[i].rt_rdy;
`endif
    end
  end

  assign mult_req = |w_rdy;
  assign w_issue  = issue_grant && mult_req;

  always_comb begin
    w_sel = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_rdy[i]) w_sel = IW'(i);
    end
  end

  assign w_disp_acc    = dispatch_en && !r_full;
  assign w_disp_rs_hit = !dispatch_rs_valid && w_cdb_vld && (dispatch_rs_tag == w_cdb_tag);
  assign w_disp_rt_hit = !dispatch_rt_valid && w_cdb_vld && (dispatch_rt_tag == w_cdb_tag);
  assign w_wr_idx      = r_count - CW'(w_issue);
  assign w_count_nxt   = r_count + CW'(w_disp_acc) - CW'(w_issue);

  always_comb begin
    w_new         = '0;
    w_new.vld     = 1'b1;
    w_new.rs_tag  = dispatch_rs_tag;
    w_new.rt_tag  = dispatch_rt_tag;
    w_new.rd_tag  = dispatch_rd_tag;
    w_new.rs_rdy  = dispatch_rs_valid | w_disp_rs_hit;
    w_new.rt_rdy  = dispatch_rt_valid | w_disp_rt_hit;
    w_new.rs_data = w_disp_rs_hit ? w_cdb_data : dispatch_rs_data;
    w_new.rt_data = w_disp_rt_hit ? w_cdb_data : dispatch_rt_data;
  end

  // Collapse over the issued slot, then append the dispatch at the compacted tail.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_next[i] = w_woken[i];
    end
    if (w_issue) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (IW'(i) >= w_sel) w_next[i] = w_woken[i+1];
      end
      w_next[DEPTH-1] = '0;
    end
    if (w_disp_acc) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == w_wr_idx) w_next[i] = w_new;
      end
    end
  end

  always_comb begin
    w_word = '0;
    if (w_issue) begin
      w_word.issueblk_done    = 1'b1;
      w_word.issueque_rs_data = w_woken[w_sel].rs_data;
      w_word.issueque_rt_data = w_woken[w_sel].rt_data;
      w_word.issueque_rd_tag  = w_woken[w_sel].rd_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i] <= '0;
      end
      r_count <= '0;
      r_full  <= 1'b0;
      r_issue <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i].vld <= 1'b0;
      end
      r_count <= '0;
      r_full  <= 1'b0;
      r_issue <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i] <= w_next[i];
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_issue <= w_word;
    end
  end

  assign queue_full          = r_full;
  assign queue_count         = r_count;
  assign mult_data_exec_unit = r_issue;

endmodule

// File: tb/tb_mult_issue_queue.sv
// Self-checking bench for mult_issue_queue: directed scenarios plus randomized traffic against a queue-based model.
// Honours MULT_IQ_BYPASS_EN when defined for the build.

module tb_mult_issue_queue;
  import mult_iq_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic              clk;
  logic              rst;
  logic              dispatch_en;
  logic [31:0]       dispatch_rs_data;
  logic [5:0]        dispatch_rs_tag;
  logic              dispatch_rs_valid;
  logic [31:0]       dispatch_rt_data;
  logic [5:0]        dispatch_rt_tag;
  logic              dispatch_rt_valid;
  logic [5:0]        dispatch_rd_tag;
  cdb_bus            cdb;
  logic              flush;
  logic              issue_grant;
  logic              mult_req;
  logic              queue_full;
  logic [CW-1:0]     queue_count;
  int_data_exec_unit word;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rs_rdy;
    logic [5:0]  rs_tag;
    logic [31:0] rs_data;
    logic        rt_rdy;
    logic [5:0]  rt_tag;
    logic [31:0] rt_data;
    logic [5:0]  rd_tag;
  } m_ent_t;

  m_ent_t            mq[$];
  int_data_exec_unit exp_word;
  int                exp_count;
  logic              exp_full;

  mult_issue_queue #(.DEPTH(DEPTH), .TAG_W(6), .DATA_W(32)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .dispatch_en         (dispatch_en),
    .dispatch_rs_data    (dispatch_rs_data),
    .dispatch_rs_tag     (dispatch_rs_tag),
    .dispatch_rs_valid   (dispatch_rs_valid),
    .dispatch_rt_data    (dispatch_rt_data),
    .dispatch_rt_tag     (dispatch_rt_tag),
    .dispatch_rt_valid   (dispatch_rt_valid),
    .dispatch_rd_tag     (dispatch_rd_tag),
    .cdb_mult_snoop      (cdb),
    .flush               (flush),
    .issue_grant         (issue_grant),
    .mult_req            (mult_req),
    .queue_full          (queue_full),
    .queue_count         (queue_count),
    .mult_data_exec_unit (word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int_data_exec_unit mk_word(input logic [31:0] rs, input logic [31:0] rt, input logic [5:0] rd);
    int_data_exec_unit w;
    w.issueblk_done    = 1'b1;
    w.issueque_rs_data = rs;
    w.issueque_rt_data = rt;
    w.issueque_rd_tag  = rd;
    return w;
  endfunction

  // An instruction is issuable when both operands are known; with bypass, a CDB hit this cycle counts.
  function automatic logic m_ready(input m_ent_t e);
    logic a;
    logic b;
    a = e.rs_rdy;
    b = e.rt_rdy;
`ifdef MULT_IQ_BYPASS_EN
    if (cdb.cdb_valid && e.rs_tag == cdb.cdb_tag) a = 1'b1;
    if (cdb.cdb_valid && e.rt_tag == cdb.cdb_tag) b = 1'b1;
`endif
    return a && b;
  endfunction

  function automatic logic m_any_ready();
    logic r;
    r = 1'b0;
    foreach (mq[i]) if (m_ready(mq[i])) r = 1'b1;
    return r;
  endfunction

  function automatic m_ent_t m_wake(input m_ent_t e);
    m_ent_t o;
    o = e;
    if (cdb.cdb_valid && !o.rs_rdy && o.rs_tag == cdb.cdb_tag) begin
      o.rs_rdy  = 1'b1;
      o.rs_data = cdb.cdb_data;
    end
    if (cdb.cdb_valid && !o.rt_rdy && o.rt_tag == cdb.cdb_tag) begin
      o.rt_rdy  = 1'b1;
      o.rt_data = cdb.cdb_data;
    end
    return o;
  endfunction

  task automatic model_step();
    int     sel;
    int     n;
    m_ent_t e;
    sel      = -1;
    n        = mq.size();
    exp_word = '0;
    if (rst || flush) begin
      mq.delete();
    end else begin
      for (int i = 0; i < n; i++) if (sel < 0 && m_ready(mq[i])) sel = i;
      for (int i = 0; i < n; i++) mq[i] = m_wake(mq[i]);
      if (issue_grant && sel >= 0) begin
        exp_word = mk_word(mq[sel].rs_data, mq[sel].rt_data, mq[sel].rd_tag);
        mq.delete(sel);
      end
      if (dispatch_en && n < DEPTH) begin
        e.rs_rdy  = dispatch_rs_valid;
        e.rs_tag  = dispatch_rs_tag;
        e.rs_data = dispatch_rs_data;
        e.rt_rdy  = dispatch_rt_valid;
        e.rt_tag  = dispatch_rt_tag;
        e.rt_data = dispatch_rt_data;
        e.rd_tag  = dispatch_rd_tag;
        mq.push_back(m_wake(e));
      end
    end
    exp_count = mq.size();
    exp_full  = (exp_count == DEPTH);
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0; issue_grant = 1'b0; dispatch_en = 1'b0;
    dispatch_rs_valid = 1'b0; dispatch_rs_tag = '0; dispatch_rs_data = '0;
    dispatch_rt_valid = 1'b0; dispatch_rt_tag = '0; dispatch_rt_data = '0;
    dispatch_rd_tag = '0; cdb = '0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic set_disp(input logic a_rsv, input logic [5:0] a_rst, input logic [31:0] a_rsd,
                          input logic a_rtv, input logic [5:0] a_rtt, input logic [31:0] a_rtd,
                          input logic [5:0] a_rd);
    dispatch_en = 1'b1;
    dispatch_rs_valid = a_rsv; dispatch_rs_tag = a_rst; dispatch_rs_data = a_rsd;
    dispatch_rt_valid = a_rtv; dispatch_rt_tag = a_rtt; dispatch_rt_data = a_rtd;
    dispatch_rd_tag = a_rd;
  endtask

  task automatic set_cdb(input logic [5:0] t, input logic [31:0] d);
    cdb.cdb_valid = 1'b1;
    cdb.cdb_tag   = t;
    cdb.cdb_data  = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    checks++; if (queue_count !== CW'(0)) begin errors++; $display("FAIL reset_count got %0d want 0", queue_count); end
    checks++; if (queue_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", queue_full); end
    checks++; if (word !== '0) begin errors++; $display("FAIL reset_word got %h want 0", word); end
    checks++; if (mult_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", mult_req); end
  endtask

  task automatic test_basic_issue();
    set_disp(1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd7, 6'd3);
    issue_grant = 1'b1;
    #1;
    checks++; if (mult_req !== 1'b0) begin errors++; $display("FAIL basic_req_empty got %b want 0", mult_req); end
    tick();
    checks++; if (queue_count !== CW'(1)) begin errors++; $display("FAIL basic_count1 got %0d want 1", queue_count); end
    issue_grant = 1'b1;
    #1;
    checks++; if (mult_req !== 1'b1) begin errors++; $display("FAIL basic_req got %b want 1", mult_req); end
    tick();
    checks++; if (word !== mk_word(32'd5, 32'd7, 6'd3)) begin errors++; $display("FAIL basic_word got %h want %h", word, mk_word(32'd5, 32'd7, 6'd3)); end
    checks++; if (queue_count !== CW'(0)) begin errors++; $display("FAIL basic_count0 got %0d want 0", queue_count); end
  endtask

  task automatic test_wakeup();
    set_disp(1'b0, 6'd9, 32'd0, 1'b1, 6'd0, 32'd4, 6'd10);
    tick();
    issue_grant = 1'b1;
    tick();
    checks++; if (word.issueblk_done !== 1'b0) begin errors++; $display("FAIL wake_early got %b want 0", word.issueblk_done); end
    issue_grant = 1'b1;
    set_cdb(6'd9, 32'd6);
    tick();
`ifndef MULT_IQ_BYPASS_EN
    checks++; if (word.issueblk_done !== 1'b0) begin errors++; $display("FAIL wake_same_cycle got %b want 0", word.issueblk_done); end
    issue_grant = 1'b1;
    tick();
`endif
    checks++; if (word !== mk_word(32'd6, 32'd4, 6'd10)) begin errors++; $display("FAIL wake_word got %h want %h", word, mk_word(32'd6, 32'd4, 6'd10)); end
    checks++; if (queue_count !== CW'(0)) begin errors++; $display("FAIL wake_count got %0d want 0", queue_count); end
  endtask

  task automatic test_full();
    for (int k = 0; k < 4; k++) begin
      set_disp(1'b1, 6'd0, 32'(100 + k), 1'b1, 6'd0, 32'(200 + k), 6'(k + 1));
      tick();
    end
    checks++; if (queue_full !== 1'b1) begin errors++; $display("FAIL full_flag got %b want 1", queue_full); end
    set_disp(1'b1, 6'd0, 32'd999, 1'b1, 6'd0, 32'd999, 6'd7);
    tick();
    checks++; if (queue_count !== CW'(4)) begin errors++; $display("FAIL full_drop got %0d want 4", queue_count); end
    set_disp(1'b1, 6'd0, 32'd888, 1'b1, 6'd0, 32'd888, 6'd8);
    issue_grant = 1'b1;
    tick();
    checks++; if (word !== mk_word(32'd100, 32'd200, 6'd1)) begin errors++; $display("FAIL full_issue got %h want %h", word, mk_word(32'd100, 32'd200, 6'd1)); end
    checks++; if (queue_count !== CW'(3)) begin errors++; $display("FAIL full_issue_count got %0d want 3", queue_count); end
    checks++; if (queue_full !== 1'b0) begin errors++; $display("FAIL full_clear got %b want 0", queue_full); end
    for (int k = 1; k < 4; k++) begin
      issue_grant = 1'b1;
      tick();
      checks++; if (word !== mk_word(32'(100 + k), 32'(200 + k), 6'(k + 1))) begin errors++; $display("FAIL full_drain%0d got %h want %h", k, word, mk_word(32'(100 + k), 32'(200 + k), 6'(k + 1))); end
    end
  endtask

  task automatic test_out_of_order();
    logic [5:0]  wt [2];
    logic [31:0] wd [2];
    logic [31:0] wr [2];
    logic [5:0]  wrd [2];
    wt  = '{6'd21, 6'd20};
    wd  = '{32'd50, 32'd60};
    wr  = '{32'd5, 32'd2};
    wrd = '{6'd13, 6'd11};
    set_disp(1'b0, 6'd20, 32'd0, 1'b1, 6'd0, 32'd2, 6'd11);
    tick();
    set_disp(1'b1, 6'd0, 32'd3, 1'b1, 6'd0, 32'd4, 6'd12);
    tick();
    set_disp(1'b0, 6'd21, 32'd0, 1'b1, 6'd0, 32'd5, 6'd13);
    tick();
    issue_grant = 1'b1;
    tick();
    checks++; if (word !== mk_word(32'd3, 32'd4, 6'd12)) begin errors++; $display("FAIL ooo_first got %h want %h", word, mk_word(32'd3, 32'd4, 6'd12)); end
    checks++; if (queue_count !== CW'(2)) begin errors++; $display("FAIL ooo_count got %0d want 2", queue_count); end
    for (int j = 0; j < 2; j++) begin
      issue_grant = 1'b1;
      set_cdb(wt[j], wd[j]);
      tick();
`ifndef MULT_IQ_BYPASS_EN
      checks++; if (word.issueblk_done !== 1'b0) begin errors++; $display("FAIL ooo_wait%0d got %b want 0", j, word.issueblk_done); end
      issue_grant = 1'b1;
      tick();
`endif
      checks++; if (word !== mk_word(wd[j], wr[j], wrd[j])) begin errors++; $display("FAIL ooo_wake%0d got %h want %h", j, word, mk_word(wd[j], wr[j], wrd[j])); end
    end
  endtask

  task automatic test_dispatch_cdb();
    set_disp(1'b0, 6'd12, 32'd0, 1'b1, 6'd0, 32'd9, 6'd14);
    set_cdb(6'd12, 32'h100);
    tick();
    issue_grant = 1'b1;
    #1;
    checks++; if (mult_req !== 1'b1) begin errors++; $display("FAIL dcdb_req got %b want 1", mult_req); end
    tick();
    checks++; if (word !== mk_word(32'h100, 32'd9, 6'd14)) begin errors++; $display("FAIL dcdb_word got %h want %h", word, mk_word(32'h100, 32'd9, 6'd14)); end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      set_disp(1'b1, 6'd0, 32'(k + 40), 1'b1, 6'd0, 32'(k + 50), 6'(k + 20));
      tick();
    end
    flush = 1'b1;
    issue_grant = 1'b1;
    set_disp(1'b1, 6'd0, 32'd77, 1'b1, 6'd0, 32'd78, 6'd30);
    tick();
    checks++; if (queue_count !== CW'(0)) begin errors++; $display("FAIL flush_count got %0d want 0", queue_count); end
    checks++; if (word.issueblk_done !== 1'b0) begin errors++; $display("FAIL flush_done got %b want 0", word.issueblk_done); end
    for (int k = 0; k < 3; k++) begin
      issue_grant = 1'b1;
      #1;
      checks++; if (mult_req !== 1'b0) begin errors++; $display("FAIL flush_req%0d got %b want 0", k, mult_req); end
      tick();
      checks++; if (word.issueblk_done !== 1'b0) begin errors++; $display("FAIL flush_after%0d got %b want 0", k, word.issueblk_done); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) < 60)
        set_disp(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom, 6'($urandom_range(0, 63)));
      if ($urandom_range(0, 99) < 45) set_cdb(6'($urandom_range(0, 7)), $urandom);
      cdb.cdb_branch       = 1'($urandom_range(0, 1));
      cdb.cdb_branch_taken = 1'($urandom_range(0, 1));
      issue_grant = ($urandom_range(0, 99) < 60);
      flush       = ($urandom_range(0, 99) < 2);
      rst         = ($urandom_range(0, 199) < 1);
      #1;
      checks++; if (mult_req !== m_any_ready()) begin errors++; $display("FAIL rnd_req c%0d got %b want %b", c, mult_req, m_any_ready()); end
      tick();
      checks++; if (word !== exp_word) begin errors++; $display("FAIL rnd_word c%0d got %h want %h", c, word, exp_word); end
      checks++; if (queue_count !== CW'(exp_count)) begin errors++; $display("FAIL rnd_count c%0d got %0d want %0d", c, queue_count, exp_count); end
      checks++; if (queue_full !== exp_full) begin errors++; $display("FAIL rnd_full c%0d got %b want %b", c, queue_full, exp_full); end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_basic_issue();
    test_wakeup();
    test_full();
    test_out_of_order();
    test_dispatch_cdb();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_issue_queue.md
Name: mult_issue_queue

Overview:
- Issue queue that feeds the multiply execution unit. It is the producer side of the int_data_exec_unit interface that the multiplier consumes.
- Holds dispatched multiply instructions and snoops the CDB for outstanding source operand tags.
- Selects the oldest instruction whose operands are both ready, and presents it to the multiplier as a registered int_data_exec_unit word.
- Sits between dispatch and mult_exec_unit, alongside the integer and load/store issue queues.

Parameters:
DEPTH, 4, number of queue entries (2..8)
TAG_W, 6, width of physical register tags; must match cdb_tag width
DATA_W, 32, operand data width; must match cdb_data width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
dispatch_en  input  1  write one instruction into the queue this cycle
dispatch_rs_data  input  DATA_W  rs value, meaningful when dispatch_rs_valid=1
dispatch_rs_tag  input  TAG_W  rs producer tag, meaningful when dispatch_rs_valid=0
dispatch_rs_valid  input  1  rs value already available
dispatch_rt_data  input  DATA_W  rt value
dispatch_rt_tag  input  TAG_W  rt producer tag
dispatch_rt_valid  input  1  rt value already available
dispatch_rd_tag  input  TAG_W  destination tag
cdb_mult_snoop  input  cdb_bus  CDB broadcast (cdb_valid, cdb_tag, cdb_data used; branch fields ignored)
flush  input  1  discard all entries (mispredict recovery)
issue_grant  input  1  multiplier/CDB slot available this cycle
mult_req  output  1  at least one ready entry exists (combinational)
queue_full  output  1  registered; all DEPTH entries occupied
queue_count  output  $clog2(DEPTH+1)  registered occupancy
mult_data_exec_unit  output  int_data_exec_unit  registered issue word to mult_exec_unit

Behaviour:
- Clocking: single clock; reset is synchronous and active-high. All state updates on posedge clk.
- Reset: all entry valid bits 0; queue_count=0; queue_full=0; mult_data_exec_unit all zeros (issueblk_done=0).
- Storage organisation: collapsing queue. Entry 0 is the oldest. Each entry holds valid, rs_rdy, rs_tag, rs_data, rt_rdy, rt_tag, rt_data, rd_tag.
- Ready condition: an entry is ready when valid && rs_rdy && rt_rdy, evaluated on registered state.
- mult_req = OR over all ready entries.
- Issue selection:
  - When issue_grant && mult_req, the lowest-index ready entry is selected.
  - At the next edge, mult_data_exec_unit is loaded with issueblk_done=1, issueque_rs_data, issueque_rt_data and issueque_rd_tag from that entry.
  - Entries above the selected one shift down by one.
  - Otherwise issueblk_done=0 and the data/tag fields are zeroed.
  - Latency is 1 cycle from grant to output valid.
- CDB wakeup: when cdb_valid=1, every valid entry with a not-ready operand whose tag equals cdb_tag captures cdb_data and sets the corresponding rdy bit at the edge. Both operands of one entry may wake in the same cycle.
- Dispatch:
  - Accepted only when dispatch_en && !queue_full (queue_full is the registered value). A dispatch while full is silently dropped; upstream must stall.
  - The new entry is written at index (count - issued_this_cycle), i.e. immediately after the post-compaction tail.
- Dispatch + CDB same cycle: if a dispatched operand is not valid but its tag matches an active CDB broadcast, the entry is written with that operand ready and carrying cdb_data.
- Simultaneous issue, dispatch and wakeup are all legal in one cycle. queue_count updates by +dispatch_accepted - issued.
- Full plus issue: while full, dispatch is still rejected even if an issue frees a slot that cycle. No same-cycle reuse of the freed slot.
- Flush:
  - Has priority over dispatch, issue and wakeup.
  - At the next edge: all valid bits 0, queue_count=0, queue_full=0, mult_data_exec_unit zeroed.
  - An issue word already registered before the flush is not recalled.
- Reset during operation behaves as flush, plus zeroing of all stored fields.

Optional Feature:
MULT_IQ_BYPASS_EN:
- Defined: an entry whose last missing operand is woken by the CDB in cycle t counts as ready in cycle t. mult_req and selection include it, and the issued word carries cdb_data directly, saving one cycle of wakeup-to-issue latency.
- Undefined: woken entries are first issuable in cycle t+1.

Test Plan:
1. Reset, then dispatch rs=5, rt=7, both valid, rd_tag=3, with issue_grant=1 -> one cycle later issueblk_done=1, rs=5, rt=7, rd_tag=3; queue_count returns to 0.
2. Dispatch rs_tag=9 not valid, rt=4 valid; after 2 cycles drive cdb_valid=1, cdb_tag=9, cdb_data=6 -> issue word rs=6, rt=4 on the cycle after wakeup+1 (one cycle earlier with MULT_IQ_BYPASS_EN).
3. Fill 4 entries with grant=0 -> queue_full=1; a 5th dispatch is dropped. Grant once -> entry 0 issues, count=3, queue_full=0 the next cycle.
4. Entries 0 and 2 waiting, entry 1 ready, grant=1 -> entry 1 issues first. Entry 2 shifts to index 1 and retains its tags.
5. Dispatch with rs_tag=12 in the same cycle as cdb_tag=12, cdb_data=0x100 -> entry captures 0x100 and issues with rs=0x100.
6. Three entries queued, assert flush together with dispatch_en and issue_grant -> next cycle count=0, issueblk_done=0, and nothing is issued afterwards.
